// File: rtl/phy_rx_pkg.sv
// Shared PHY RX definitions: alignment symbols, deskew FSM encoding and the per-lane symbol record.
package phy_rx_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WINDOW  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ALIGNED = 3'd3,
        ST_ERROR   = 3'd4
    } deskew_state_t;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } lane_sym_t;

    function automatic logic is_com(input lane_sym_t s);
        return s.k && (s.data == COM);
    endfunction

endpackage

// File: rtl/phy_rx_deskew_ctrl_if.sv
// Lane-side bus of the RX deskew controller: elastic-buffer inputs, aligned outputs and status.
interface phy_rx_deskew_ctrl_if #(parameter int NUM_LANES = 4);

    logic                           retrain;
    logic [NUM_LANES-1:0]           lane_ts_obtained;
    logic [NUM_LANES-1:0]           lane_in_valid;
    logic [NUM_LANES-1:0][7:0]      lane_data_in;
    logic [NUM_LANES-1:0]           lane_k_in;
    logic [NUM_LANES-1:0][7:0]      lane_data_out;
    logic [NUM_LANES-1:0]           lane_k_out;
    logic                           out_valid;
    logic                           deskew_done;
    logic                           deskew_err;

    modport master (
        output retrain, lane_ts_obtained, lane_in_valid, lane_data_in, lane_k_in,
        input  lane_data_out, lane_k_out, out_valid, deskew_done, deskew_err
    );

    modport slave (
        input  retrain, lane_ts_obtained, lane_in_valid, lane_data_in, lane_k_in,
        output lane_data_out, lane_k_out, out_valid, deskew_done, deskew_err
    );

endinterface

// File: rtl/deskew_lane_fifo.sv
// Per-lane deskew FIFO; pointers carry an extra wrap bit so full/empty come from the MSB compare.
module deskew_lane_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_r_local,
    input  logic       rstn_asyn,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [8:0] din,
    output logic [8:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr, rptr;
    logic [8:0]  mem [DEPTH];

    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_r_local) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/phy_rx_deskew_ctrl.sv
// N-lane count-window deskew: wait for TS on all lanes, sit out MAX_SKEW cycles, capture from each lane's COM,
// pop all lanes in lock-step. Optional cross-lane COM check with PHY_RX_DESKEW_CHECK_EN.
module phy_rx_deskew_ctrl
    import phy_rx_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = 4,
    parameter int DEPTH     = 8
) (
    input  logic                  clk_r_local,
    input  logic                  rstn_asyn,
    phy_rx_deskew_ctrl_if.slave   bus
);

    localparam int WCW = $clog2(MAX_SKEW + 1);

    deskew_state_t              state;
    logic [WCW-1:0]             win_cnt;
    logic [NUM_LANES-1:0]       started, lane_com, push, full, empty;
    lane_sym_t [NUM_LANES-1:0]  din, dout;
    logic                       ts_all, armed, ts_drop, flush, pop, overflow, misalign;

    assign ts_all  = &bus.lane_ts_obtained;
    assign armed   = (state == ST_CAPTURE) || (state == ST_ALIGNED);
    assign ts_drop = !ts_all && (state inside {ST_WINDOW, ST_CAPTURE, ST_ALIGNED});
    assign flush   = bus.retrain | ts_drop;
    assign pop     = armed && !flush && !(|empty);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign din[i]      = '{k: bus.lane_k_in[i], data: bus.lane_data_in[i]};
        assign lane_com[i] = bus.lane_in_valid[i] && is_com(din[i]);
        assign push[i]     = armed && !flush && bus.lane_in_valid[i] && (started[i] || lane_com[i]);

        // a full FIFO still accepts a write in the cycle it is popped
        deskew_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_r_local (clk_r_local),
            .rstn_asyn   (rstn_asyn),
            .push        (push[i] && (!full[i] || pop)),
            .pop         (pop),
            .flush       (flush),
            .din         (din[i]),
            .dout        (dout[i]),
            .full        (full[i]),
            .empty       (empty[i])
        );
    end

    assign overflow = |(push & full) && !pop;

`ifdef PHY_RX_DESKEW_CHECK_EN
    logic [NUM_LANES-1:0] head_com;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chk
        assign head_com[i] = is_com(dout[i]);
    end
    assign misalign = pop && (state == ST_ALIGNED) && (|head_com) && !(&head_com);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn)  started <= '0;
        else if (flush)  started <= '0;
        else             started <= started | push;
    end

    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn) begin
            state           <= ST_IDLE;
            win_cnt         <= '0;
            bus.deskew_done <= 1'b0;
            bus.deskew_err  <= 1'b0;
        end else if (bus.retrain) begin
            state           <= ST_IDLE;
            win_cnt         <= '0;
            bus.deskew_done <= 1'b0;
            bus.deskew_err  <= 1'b0;
        end else if (ts_drop) begin
            state           <= ST_IDLE;
            bus.deskew_done <= 1'b0;
        end else if (overflow || misalign) begin
            state           <= ST_ERROR;
            bus.deskew_done <= 1'b0;
            bus.deskew_err  <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: if (ts_all) begin
                    state   <= ST_WINDOW;
                    win_cnt <= '0;
                end
                ST_WINDOW: begin
                    win_cnt <= win_cnt + 1'b1;
                    if (win_cnt == WCW'(MAX_SKEW - 1)) state <= ST_CAPTURE;
                end
                ST_CAPTURE: if (pop) begin
                    state           <= ST_ALIGNED;
                    bus.deskew_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // outputs hold their last popped value while out_valid is low
    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn) begin
            bus.out_valid     <= 1'b0;
            bus.lane_data_out <= '0;
            bus.lane_k_out    <= '0;
        end else begin
            bus.out_valid <= pop;
            if (pop) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    bus.lane_data_out[i] <= dout[i].data;
                    bus.lane_k_out[i]    <= dout[i].k;
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_deskew_ctrl.sv
// Bench for phy_rx_deskew_ctrl: vector table, directed corner sequences and a random run against a queue model.
module tb_phy_rx_deskew_ctrl;
    import phy_rx_pkg::*;

    localparam int NL = 4;
    localparam int MS = 4;
    localparam int DP = 8;
`ifdef PHY_RX_DESKEW_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    phy_rx_deskew_ctrl_if #(.NUM_LANES(NL)) bus();

    phy_rx_deskew_ctrl #(.NUM_LANES(NL), .MAX_SKEW(MS), .DEPTH(DP)) dut (
        .clk_r_local (clk),
        .rstn_asyn   (rstn),
        .bus         (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: per-lane queues and a phase tag ----------------
    typedef enum {M_IDLE, M_WIN, M_CAP, M_ALN, M_ERR} mphase_t;
    mphase_t               mph = M_IDLE;
    logic [8:0]            mq [NL][$];
    bit                    mstart [NL];
    int                    win_left = 0;
    bit                    m_err = 0, m_ov = 0;
    logic [NL-1:0][7:0]    m_data = '0;
    logic [NL-1:0]         m_k = '0;

    task automatic mflush();
        for (int i = 0; i < NL; i++) begin
            mq[i].delete();
            mstart[i] = 0;
        end
    endtask

    task automatic model_step();
        bit ts_all, armed, can_pop, ovf, mis, com_in;
        int ncom;
        logic [8:0] h;
        ts_all = &bus.lane_ts_obtained;
        if (bus.retrain) begin
            mflush(); mph = M_IDLE; m_err = 0; m_ov = 0;
            return;
        end
        if ((mph == M_WIN || mph == M_CAP || mph == M_ALN) && !ts_all) begin
            mflush(); mph = M_IDLE; m_ov = 0;
            return;
        end
        armed = (mph == M_CAP || mph == M_ALN);
        can_pop = armed;
        for (int i = 0; i < NL; i++) if (mq[i].size() == 0) can_pop = 0;
        ncom = 0;
        if (can_pop) begin
            for (int i = 0; i < NL; i++) begin
                h = mq[i].pop_front();
                m_k[i] = h[8];
                m_data[i] = h[7:0];
                if (h[8] && h[7:0] == 8'hBC) ncom++;
            end
        end
        m_ov = can_pop;
        mis = CHK && mph == M_ALN && can_pop && ncom > 0 && ncom < NL;
        ovf = 0;
        if (armed) begin
            for (int i = 0; i < NL; i++) begin
                com_in = bus.lane_k_in[i] && bus.lane_data_in[i] == 8'hBC;
                if (bus.lane_in_valid[i] && (mstart[i] || com_in)) begin
                    mstart[i] = 1;
                    if (mq[i].size() == DP) ovf = 1;
                    else mq[i].push_back({bus.lane_k_in[i], bus.lane_data_in[i]});
                end
            end
        end
        if (ovf || mis) begin
            mph = M_ERR; m_err = 1;
        end else begin
            case (mph)
                M_IDLE: if (ts_all) begin mph = M_WIN; win_left = MS; end
                M_WIN: begin win_left--; if (win_left == 0) mph = M_CAP; end
                M_CAP: if (can_pop) mph = M_ALN;
                default: ;
            endcase
        end
    endtask

    // apply the current inputs for one clock and compare everything against the model
    task automatic step(input string tag);
        model_step();
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        chk({tag, ".done"}, 32'(bus.deskew_done), 32'(mph == M_ALN));
        chk({tag, ".err"}, 32'(bus.deskew_err), 32'(m_err));
        chk({tag, ".data"}, 32'(bus.lane_data_out), 32'(m_data));
        chk({tag, ".k"}, 32'(bus.lane_k_out), 32'(m_k));
    endtask

    task automatic set_lanes(input logic [NL-1:0] vld, input logic k, input logic [7:0] d);
        for (int i = 0; i < NL; i++) begin
            bus.lane_in_valid[i] = vld[i];
            bus.lane_k_in[i]     = k;
            bus.lane_data_in[i]  = d;
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic k, input logic [7:0] d);
        bus.lane_in_valid[i] = v;
        bus.lane_k_in[i]     = k;
        bus.lane_data_in[i]  = d;
    endtask

    // from IDLE with all TS up: one IDLE cycle plus MS window cycles
    task automatic go_capture();
        bus.lane_ts_obtained = '1;
        set_lanes('0, 1'b0, 8'h00);
        repeat (MS + 1) step("win");
    endtask

    // lane0 starts with COM and writes n bytes; other lanes stream non-COM filler and never start
    task automatic lane0_fill(input int n, input bit rt_on_last);
        for (int j = 0; j < n; j++) begin
            set_lanes('1, 1'b0, 8'h00);
            set_lane(0, 1'b1, j == 0, (j == 0) ? 8'hBC : 8'(8'h50 + j));
            bus.retrain = rt_on_last && (j == n - 1);
            step("fill");
        end
        bus.retrain = 1'b0;
    endtask

    typedef struct {
        bit ts; bit vld; bit k; logic [7:0] d;
        bit e_ov; bit e_done; logic [7:0] e_d; bit e_k;
    } vec_t;
    vec_t tbl [12];

    initial begin
        logic [7:0] e;
        int nout;

        tbl[0]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[2]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[3]  = '{1, 1, 1, 8'hBC, 0, 0, 8'h00, 0};  // COM inside the window is ignored
        tbl[4]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[5]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[6]  = '{1, 1, 1, 8'hBC, 0, 0, 8'h00, 0};
        tbl[7]  = '{1, 1, 0, 8'h01, 1, 1, 8'hBC, 1};
        tbl[8]  = '{1, 1, 0, 8'h02, 1, 1, 8'h01, 0};
        tbl[9]  = '{1, 1, 0, 8'h03, 1, 1, 8'h02, 0};
        tbl[10] = '{1, 0, 0, 8'h00, 1, 1, 8'h03, 0};
        tbl[11] = '{1, 0, 0, 8'h00, 0, 1, 8'h03, 0};

        bus.retrain = 1'b0;
        bus.lane_ts_obtained = '0;
        set_lanes('0, 1'b0, 8'h00);
        mflush();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 0);
        chk("rst.done", 32'(bus.deskew_done), 0);
        chk("rst.err", 32'(bus.deskew_err), 0);
        chk("rst.data", 32'(bus.lane_data_out), 0);
        chk("rst.k", 32'(bus.lane_k_out), 0);
        rstn = 1'b1;

        // zero-skew bring-up, vector table
        for (int i = 0; i < 12; i++) begin
            bus.lane_ts_obtained = tbl[i].ts ? '1 : '0;
            set_lanes(tbl[i].vld ? '1 : '0, tbl[i].k, tbl[i].d);
            step("t2");
            chk("t2.vec_ov", 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk("t2.vec_done", 32'(bus.deskew_done), 32'(tbl[i].e_done));
            chk("t2.vec_err", 32'(bus.deskew_err), 0);
            chk("t2.vec_data", 32'(bus.lane_data_out), {NL{tbl[i].e_d}});
            chk("t2.vec_k", 32'(bus.lane_k_out), {NL{tbl[i].e_k}});
        end

        // one-byte slip on lane1 while aligned, then COM on all lanes
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                set_lanes('1, i == 6, (i == 6) ? 8'hBC : 8'(8'h40 + i));
                if (i == 3) bus.lane_in_valid[1] = 1'b0;
            end else set_lanes('0, 1'b0, 8'h00);
            step("t6");
        end
        chk("t6.err", 32'(bus.deskew_err), 32'(CHK));
        chk("t6.done", 32'(bus.deskew_done), 32'(!CHK));

        // lane1 COM three cycles after lane0
        bus.retrain = 1'b1; set_lanes('0, 1'b0, 8'h00); step("rt");
        bus.retrain = 1'b0;
        go_capture();
        nout = 0;
        for (int j = 0; j < 16; j++) begin
            if (j < 12) begin
                set_lanes('1, j == 0, (j == 0) ? 8'hBC : 8'(8'h30 + j));
                if (j < 3) set_lane(1, 1'b1, 1'b0, 8'h77);
                else set_lane(1, 1'b1, j == 3, (j == 3) ? 8'hBC : 8'(8'h30 + j - 3));
            end else set_lanes('0, 1'b0, 8'h00);
            step("t1");
            if (bus.out_valid) begin
                e = (nout == 0) ? 8'hBC : 8'(8'h30 + nout);
                chk("t1.lockstep_data", 32'(bus.lane_data_out), {NL{e}});
                chk("t1.lockstep_k", 32'(bus.lane_k_out), {NL{nout == 0}});
                nout++;
            end
        end
        chk("t1.nout", nout, 9);

        // TS drop mid-capture, then a fresh window
        bus.retrain = 1'b1; step("rt");
        bus.retrain = 1'b0;
        go_capture();
        lane0_fill(3, 1'b0);
        bus.lane_ts_obtained = 4'b1011; set_lanes('0, 1'b0, 8'h00); step("t4");
        chk("t4.drop_ov", 32'(bus.out_valid), 0);
        bus.lane_ts_obtained = '1;
        repeat (4) step("t4");
        set_lanes('1, 1'b1, 8'hBC); step("t4");           // last window cycle
        set_lanes('1, 1'b0, 8'h55); step("t4");
        chk("t4.window_len", 32'(bus.out_valid), 0);
        set_lanes('1, 1'b1, 8'hBC); step("t4");
        chk("t4.no_early", 32'(bus.out_valid), 0);
        set_lanes('1, 1'b0, 8'h66); step("t4");
        chk("t4.first_ov", 32'(bus.out_valid), 1);
        chk("t4.first_com", 32'(bus.lane_data_out), {NL{8'hBC}});
        set_lanes('0, 1'b0, 8'h00); step("t4");
        chk("t4.flushed", 32'(bus.lane_data_out), {NL{8'h66}});

        // overflow on the 9th lane0 write
        bus.retrain = 1'b1; step("rt");
        bus.retrain = 1'b0;
        go_capture();
        lane0_fill(DP, 1'b0);
        chk("t3.full_no_err", 32'(bus.deskew_err), 0);
        lane0_fill(1, 1'b0);
        chk("t3.ovf_err", 32'(bus.deskew_err), 1);
        chk("t3.ovf_done", 32'(bus.deskew_done), 0);
        set_lanes('0, 1'b0, 8'h00); step("t3");
        chk("t3.ovf_ov", 32'(bus.out_valid), 0);

        // retrain clears the sticky error; retrain beats a same-cycle overflow
        bus.retrain = 1'b1; step("t5");
        bus.retrain = 1'b0;
        chk("t5.rt_err", 32'(bus.deskew_err), 0);
        go_capture();
        lane0_fill(DP + 1, 1'b1);
        chk("t5.rt_ovf_err", 32'(bus.deskew_err), 0);
        set_lanes('0, 1'b0, 8'h00); step("t5");
        chk("t5.rt_ovf_err2", 32'(bus.deskew_err), 0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bus.lane_ts_obtained = ($urandom_range(99) < 4) ? NL'($urandom) : '1;
            bus.retrain = (mph == M_ERR && $urandom_range(9) == 0) || ($urandom_range(199) == 0);
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(4) == 0) set_lane(i, $urandom_range(99) < 85, 1'b1, 8'hBC);
                else set_lane(i, $urandom_range(99) < 85, $urandom_range(19) == 0, 8'($urandom));
            end
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
